// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the keypad-to-calculator sequencer.
// Display words are 32-bit and resized to DATA_W where used.
package calc_pkg;

   localparam logic [2:0] OP_EQU   = 3'd0;
   localparam logic [2:0] OP_TIMES = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_PLUS  = 3'd3;
   localparam logic [2:0] OP_MINUS = 3'd4;
   localparam logic [2:0] OP_MOD   = 3'd5;

   localparam logic [3:0] KEY_DIV   = 4'hA;
   localparam logic [3:0] KEY_TIMES = 4'hB;
   localparam logic [3:0] KEY_PM    = 4'hC;
   localparam logic [3:0] KEY_AC    = 4'hD;
   localparam logic [3:0] KEY_ANS   = 4'hE;
   localparam logic [3:0] KEY_EQ    = 4'hF;

   localparam logic [31:0] FND_BLANK    = 32'h00CC_0000;
   localparam logic [31:0] FND_NEG_ZERO = 32'hE000_0000;
   localparam logic [31:0] FND_ANS      = 32'h00B0_0000;
   localparam logic [31:0] FND_NEG_ANS  = 32'hE0B0_0000;
   localparam logic [31:0] FND_ERR      = 32'h00EE_0000;

   typedef enum logic [2:0] {
      IDLE, OPA, OPR, OPB, CALC, RESULT, ERROR
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous key FIFO; a push while full is accepted only when a pop
// frees a slot on the same edge.
module key_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 4
) (
   input  logic             sw_clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] buf_q [DEPTH];
   logic [WIDTH-1:0] buf_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_pop, do_push;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign dout    = buf_q[rd_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      buf_d = buf_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (do_push) begin
         buf_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop)
         rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge sw_clk)
      buf_q <= buf_d;

   always_ff @(posedge sw_clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/key_calc_sequencer.sv
// Keypad front end: key FIFO plus operand/operator sequencer for the calculator core.
// Optional KEY_CALC_DIV0_CHECK_EN: trap DIV/MOD by zero locally instead of starting the core.
module key_calc_sequencer
   import calc_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int MAX_DIGITS = 6,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              sw_clk,
   input  logic              rst,
   input  logic              key_valid,
   input  logic [3:0]        key_code,
   input  logic [DATA_W-1:0] ans,
   input  logic              ans_valid,
   input  logic              ans_err,
   output logic [DATA_W-1:0] operand1,
   output logic [DATA_W-1:0] operand2,
   output logic [2:0]        operator,
   output logic              cal_start,
   output logic              key_drop,
   output logic [DATA_W-1:0] fnd_serial
);

   localparam int CW = $clog2(MAX_DIGITS + 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [DATA_W-1:0] mem_q, mem_d, fnd_q, fnd_d;
   logic [2:0]        opr_q, opr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic              used_q, used_d;
   logic              cal_start_q, cal_start_d;
   logic              key_drop_q, key_drop_d;

   logic              pop, empty, full;
   logic [3:0]        key;
   logic [DATA_W-1:0] opnd, fin, nxt, wr_val;
   logic [CW-1:0]     lim;
   logic              wr_en, div0;

   key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
      .sw_clk (sw_clk),
      .rst    (rst),
      .push   (key_valid),
      .din    (key_code),
      .pop    (pop),
      .dout   (key),
      .empty  (empty),
      .full   (full)
   );

   function automatic logic [DATA_W-1:0] opr_disp(input logic [2:0] o);
      return DATA_W'({o, 20'h0});
   endfunction

   // An ANS recall is already signed, so it must not be negated again on exit
   assign opnd = (state_q == OPB) ? op2_q : op1_q;
   assign fin  = (sign_q && !used_q) ? -opnd : opnd;
   assign lim  = sign_q ? CW'(MAX_DIGITS - 1) : CW'(MAX_DIGITS);

`ifdef KEY_CALC_DIV0_CHECK_EN
   assign div0 = (opr_q == OP_DIV || opr_q == OP_MOD) && (fin == '0);
`else
   assign div0 = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      opr_d       = opr_q;
      mem_d       = mem_q;
      fnd_d       = fnd_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      used_d      = used_q;
      cal_start_d = 1'b0;
      key_drop_d  = key_drop_q | (key_valid && full && !pop);
      pop         = 1'b0;
      nxt         = '0;
      wr_val      = '0;
      wr_en       = 1'b0;

      if (state_q == CALC) begin
         if (ans_valid) begin
            if (ans_err) begin
               fnd_d   = DATA_W'(FND_ERR);
               state_d = ERROR;
            end else begin
               mem_d   = ans;
               fnd_d   = ans;
               state_d = RESULT;
            end
         end
      end else if (!empty) begin
         if (key == KEY_AC) begin
            pop     = 1'b1;
            op1_d   = '0;
            op2_d   = '0;
            opr_d   = OP_EQU;
            sign_d  = 1'b0;
            cnt_d   = '0;
            used_d  = 1'b0;
            fnd_d   = '0;
            state_d = IDLE;
         end else begin
            unique case (state_q)
               IDLE: begin
                  op1_d   = '0;
                  op2_d   = '0;
                  opr_d   = OP_EQU;
                  sign_d  = 1'b0;
                  cnt_d   = '0;
                  used_d  = 1'b0;
                  fnd_d   = '0;
                  state_d = OPA;
               end
               OPA, OPB: begin
                  if (is_digit(key)) begin
                     pop = 1'b1;
                     if (cnt_q < lim) begin
                        nxt    = opnd * DATA_W'(10) + DATA_W'(key);
                        wr_en  = 1'b1;
                        wr_val = nxt;
                        cnt_d  = cnt_q + CW'(1);
                        fnd_d  = sign_q ? -nxt : nxt;
                     end
                  end else if (key == KEY_PM && cnt_q == '0) begin
                     pop    = 1'b1;
                     sign_d = !sign_q;
                     fnd_d  = !sign_q ? DATA_W'(FND_NEG_ZERO) : '0;
                  end else if (key == KEY_ANS && cnt_q == '0) begin
                     pop    = 1'b1;
                     wr_en  = 1'b1;
                     wr_val = sign_q ? -mem_q : mem_q;
                     cnt_d  = lim;
                     used_d = 1'b1;
                     fnd_d  = sign_q ? DATA_W'(FND_NEG_ANS) : DATA_W'(FND_ANS);
                  end else if (cnt_q != '0 && key != KEY_ANS) begin
                     wr_en  = 1'b1;
                     wr_val = fin;
                     sign_d = 1'b0;
                     cnt_d  = '0;
                     used_d = 1'b0;
                     if (state_q == OPA) begin
                        fnd_d   = opr_disp(opr_q);
                        state_d = OPR;
                     end else if (div0) begin
                        fnd_d   = DATA_W'(FND_ERR);
                        state_d = ERROR;
                     end else begin
                        cal_start_d = 1'b1;
                        state_d     = CALC;
                     end
                  end else begin
                     pop = 1'b1;
                  end
               end
               OPR: begin
                  if (is_digit(key) || key == KEY_ANS) begin
                     state_d = OPB;
                  end else begin
                     pop = 1'b1;
                     unique case (1'b1)
                        key == KEY_DIV:
                           opr_d = (opr_q == OP_DIV) ? OP_MOD : OP_DIV;
                        key == KEY_PM:
                           opr_d = (opr_q == OP_PLUS) ? OP_MINUS : OP_PLUS;
                        key == KEY_TIMES:
                           opr_d = OP_TIMES;
                        default: ;
                     endcase
                     fnd_d = opr_disp(opr_d);
                  end
               end
               RESULT: begin
                  if (key == KEY_EQ) begin
                     pop   = 1'b1;
                     op1_d = '0;
                     op2_d = '0;
                     opr_d = OP_EQU;
                  end else if (key == KEY_DIV || key == KEY_TIMES || key == KEY_PM) begin
                     op1_d   = mem_q;
                     op2_d   = '0;
                     sign_d  = 1'b0;
                     cnt_d   = '0;
                     used_d  = 1'b0;
                     fnd_d   = opr_disp(opr_q);
                     state_d = OPR;
                  end else begin
                     state_d = IDLE;
                  end
               end
               ERROR: pop = 1'b1;
               CALC: ;
            endcase
         end
      end

      if (wr_en) begin
         if (state_q == OPB)
            op2_d = wr_val;
         else
            op1_d = wr_val;
      end
   end

   always_ff @(posedge sw_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         op1_q       <= '0;
         op2_q       <= '0;
         opr_q       <= OP_EQU;
         mem_q       <= '0;
         fnd_q       <= DATA_W'(FND_BLANK);
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         used_q      <= 1'b0;
         cal_start_q <= 1'b0;
         key_drop_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         opr_q       <= opr_d;
         mem_q       <= mem_d;
         fnd_q       <= fnd_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         used_q      <= used_d;
         cal_start_q <= cal_start_d;
         key_drop_q  <= key_drop_d;
      end
   end

   assign operand1   = op1_q;
   assign operand2   = op2_q;
   assign operator   = opr_q;
   assign cal_start  = cal_start_q;
   assign key_drop   = key_drop_q;
   assign fnd_serial = fnd_q;

endmodule

// File: tb/tb_key_calc_sequencer.sv
// Directed bench for key_calc_sequencer with hand-computed expectations.
// Covers entry, sign, digit limits, chaining, FIFO overflow and error paths.
module tb_key_calc_sequencer;

   logic        sw_clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = '0;
   logic [31:0] ans = '0;
   logic        ans_valid = 1'b0;
   logic        ans_err = 1'b0;
   logic [31:0] operand1, operand2, fnd_serial;
   logic [2:0]  operator;
   logic        cal_start, key_drop;

   int n_tests = 0;
   int n_fail  = 0;
   int n_start = 0;
   int n0;

   key_calc_sequencer dut (
      .sw_clk     (sw_clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .ans        (ans),
      .ans_valid  (ans_valid),
      .ans_err    (ans_err),
      .operand1   (operand1),
      .operand2   (operand2),
      .operator   (operator),
      .cal_start  (cal_start),
      .key_drop   (key_drop),
      .fnd_serial (fnd_serial)
   );

   always #5 sw_clk = ~sw_clk;

   always @(negedge sw_clk)
      if (cal_start) n_start++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sw_clk);
   endtask

   task automatic send(input logic [3:0] k);
      @(negedge sw_clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge sw_clk);
      key_valid = 1'b0;
   endtask

   task automatic press(input logic [3:0] k);
      send(k);
      tick(5);
   endtask

   task automatic wait_start(input int base);
      for (int i = 0; i < 40 && n_start == base; i++)
         @(negedge sw_clk);
      check("start_seen", 32'(n_start > base), 32'd1);
   endtask

   task automatic give_ans(input logic [31:0] a, input logic err);
      tick(1);
      @(negedge sw_clk);
      ans_valid = 1'b1;
      ans       = a;
      ans_err   = err;
      @(negedge sw_clk);
      ans_valid = 1'b0;
      ans_err   = 1'b0;
      tick(4);
   endtask

   initial begin
      logic [3:0] burst [9];
      burst = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB, 4'h6, 4'h7, 4'h8};

      tick(2);
      check("rst_op1", operand1, 32'd0);
      check("rst_op2", operand2, 32'd0);
      check("rst_opr", 32'(operator), 32'd0);
      check("rst_start", 32'(cal_start), 32'd0);
      check("rst_drop", 32'(key_drop), 32'd0);
      check("rst_fnd", fnd_serial, 32'h00CC_0000);
      rst = 1'b1;
      tick(2);
      check("idle_hold_fnd", fnd_serial, 32'h00CC_0000);

      // 12 + 3 = 15
      n0 = n_start;
      press(4'h1); press(4'h2); press(4'hC); press(4'h3);
      send(4'hF);
      wait_start(n0);
      check("add_op1", operand1, 32'd12);
      check("add_op2", operand2, 32'd3);
      check("add_opr", 32'(operator), 32'd3);
      give_ans(32'd15, 1'b0);
      check("add_fnd", fnd_serial, 32'd15);
      check("add_one_start", 32'(n_start - n0), 32'd1);

      // chain: 15 * 2 = 30
      n0 = n_start;
      press(4'hB); press(4'h2);
      send(4'hF);
      wait_start(n0);
      check("chain_op1", operand1, 32'd15);
      check("chain_opr", 32'(operator), 32'd1);
      check("chain_op2", operand2, 32'd2);
      give_ans(32'd30, 1'b0);
      check("chain_fnd", fnd_serial, 32'd30);
      check("result_clear", operand1, 32'd0);

      // AC keeps mem; negative ANS recall
      press(4'hD);
      check("ac_fnd", fnd_serial, 32'd0);
      press(4'hC); press(4'hE);
      check("negans_fnd", fnd_serial, 32'hE0B0_0000);
      press(4'hF);
      check("negans_op1", operand1, 32'hFFFF_FFE2);
      press(4'hD);

      // sign toggling
      press(4'hC); press(4'hC); press(4'hC);
      check("sign_fnd", fnd_serial, 32'hE000_0000);
      press(4'h7);
      check("neg7_fnd", fnd_serial, 32'hFFFF_FFF9);
      press(4'hD);

      // digit limit, positive
      for (int i = 1; i <= 7; i++) press(4'(i));
      check("lim_pos_op1", operand1, 32'd123456);
      check("lim_pos_fnd", fnd_serial, 32'd123456);
      press(4'hD);

      // digit limit, negative
      press(4'hC);
      for (int i = 1; i <= 6; i++) press(4'(i));
      press(4'hF);
      check("lim_neg_op1", operand1, 32'hFFFF_CFC7);
      check("opr_fnd", fnd_serial, 32'd0);
      press(4'hD);

      // FIFO overflow while stalled in CALC (F still queued)
      n0 = n_start;
      press(4'h1); press(4'hC); press(4'h1);
      send(4'hF);
      wait_start(n0);
      check("pre_drop", 32'(key_drop), 32'd0);
      @(negedge sw_clk);
      for (int i = 0; i < 9; i++) begin
         key_valid = 1'b1;
         key_code  = burst[i];
         @(negedge sw_clk);
      end
      key_valid = 1'b0;
      check("drop_set", 32'(key_drop), 32'd1);
      give_ans(32'd2, 1'b0);
      tick(20);
      check("fifo_op1", operand1, 32'd12345);
      check("fifo_opr", 32'(operator), 32'd1);
      check("fifo_op2", operand2, 32'd6);
      check("fifo_fnd", fnd_serial, 32'd6);
      press(4'hD);
      check("drop_sticky", 32'(key_drop), 32'd1);

      // calculator error path
      n0 = n_start;
      press(4'h5); press(4'hB); press(4'h3);
      send(4'hF);
      wait_start(n0);
      give_ans(32'd0, 1'b1);
      check("err_fnd", fnd_serial, 32'h00EE_0000);
      press(4'h7);
      check("err_hold", fnd_serial, 32'h00EE_0000);
      press(4'hD);
      check("err_ac", fnd_serial, 32'd0);
      press(4'h5);
      check("err_idle_op1", operand1, 32'd5);
      press(4'hD);

      // stray ans_valid outside CALC
      @(negedge sw_clk);
      ans_valid = 1'b1;
      ans       = 32'd99;
      @(negedge sw_clk);
      ans_valid = 1'b0;
      tick(3);
      check("stray_ans", fnd_serial, 32'd0);

      // divide by zero
      press(4'h8); press(4'hA); press(4'h0);
      n0 = n_start;
      send(4'hF);
`ifdef KEY_CALC_DIV0_CHECK_EN
      tick(10);
      check("div0_nostart", 32'(n_start - n0), 32'd0);
`else
      wait_start(n0);
      check("div0_opr", 32'(operator), 32'd2);
      give_ans(32'd0, 1'b1);
`endif
      check("div0_fnd", fnd_serial, 32'h00EE_0000);
      press(4'hD);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
